// File: rtl/spw_light_timecode_capture.sv
// Captures SpaceWire time codes: holds last time for the PIO, checks mod-64 continuity,
// counts ticks and queues {ctrl,time} in a small FIFO for the CPU.
module spw_light_timecode_capture #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_in,
  input  logic [5:0]       time_in,
  input  logic [1:0]       ctrl_in,
  input  logic             clear,
  input  logic             pop,
  output logic [5:0]       time_out,
  output logic [7:0]       head_data,
  output logic             fifo_empty,
  output logic             fifo_ovf,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] tick_count
);

  // state     | meaning
  // ST_IDLE   | no code seen since reset/clear; next code is accepted without comparison
  // ST_LOCKED | last code followed its predecessor
  // ST_SLIP   | last code broke the sequence
  typedef enum logic [1:0] {ST_IDLE, ST_LOCKED, ST_SLIP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  state_t      state, state_nxt;
  logic [5:0]  expected;
  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        fifo_full, do_tick, do_pop, do_push, ovf_set, in_seq, err_set;

  assign do_tick    = tick_in && !clear;
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop     = pop && !clear && !fifo_empty;
  // a pop in the same cycle frees a slot for the incoming code
  assign do_push    = do_tick && (!fifo_full || do_pop);
  assign ovf_set    = do_tick && fifo_full && !do_pop;
  assign head_data  = fifo_empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ST_IDLE;
    end else if (tick_in) begin
      case (state)
        ST_IDLE:   state_nxt = ST_LOCKED;
        ST_LOCKED,
        ST_SLIP:   state_nxt = in_seq ? ST_LOCKED : ST_SLIP;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    in_seq  = (time_in == expected);
    locked  = (state == ST_LOCKED);
    err_set = do_tick && (state != ST_IDLE) && !in_seq;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      time_out   <= '0;
      expected   <= '0;
      tick_count <= '0;
      seq_err    <= 1'b0;
      fifo_ovf   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else if (clear) begin
      tick_count <= '0;
      seq_err    <= 1'b0;
      fifo_ovf   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      if (tick_in) begin
        time_out <= time_in;
        expected <= time_in + 6'd1;
        if (tick_count != '1) tick_count <= tick_count + CNT_W'(1);
      end
      if (err_set) seq_err  <= 1'b1;
      if (ovf_set) fifo_ovf <= 1'b1;
      if (do_pop)  rd_ptr   <= rd_ptr + PTR_ONE;
      if (do_push) wr_ptr   <= wr_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && do_push) mem[wr_ptr[AW-1:0]] <= {ctrl_in, time_in};
  end

endmodule

// File: tb/tb_spw_light_timecode_capture.sv
// Randomized + directed bench for spw_light_timecode_capture against a queue-based reference model.
module tb_spw_light_timecode_capture;
  localparam int DEPTH = 4;
  localparam int CW    = 4;
  localparam int CMAX  = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0, tick_in = 1'b0, clear = 1'b0, pop = 1'b0;
  logic [5:0]    time_in = '0;
  logic [1:0]    ctrl_in = '0;
  logic [5:0]    time_out;
  logic [7:0]    head_data;
  logic          fifo_empty, fifo_ovf, seq_err, locked;
  logic [CW-1:0] tick_count;

  int errors = 0;
  int checks = 0;

  // reference model
  int       m_tout, m_last, m_cnt;
  bit       m_have, m_locked, m_seq, m_ovf;
  bit [7:0] m_q[$];

  spw_light_timecode_capture #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .tick_in(tick_in), .time_in(time_in), .ctrl_in(ctrl_in),
    .clear(clear), .pop(pop), .time_out(time_out), .head_data(head_data),
    .fifo_empty(fifo_empty), .fifo_ovf(fifo_ovf), .seq_err(seq_err), .locked(locked),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tout = 0; m_last = 0; m_cnt = 0;
    m_have = 0; m_locked = 0; m_seq = 0; m_ovf = 0;
    m_q.delete();
  endtask

  task automatic model_step(input bit t, input int tv, input int c, input bit p, input bit cl);
    if (cl) begin
      m_seq = 0; m_ovf = 0; m_cnt = 0; m_have = 0; m_locked = 0;
      m_q.delete();
      return;
    end
    if (p && m_q.size() > 0) void'(m_q.pop_front());
    if (t) begin
      if (m_have) begin
        m_locked = (tv == ((m_last + 1) % 64));
        if (!m_locked) m_seq = 1;
      end else begin
        m_locked = 1;
      end
      m_have = 1;
      m_last = tv;
      m_tout = tv;
      if (m_cnt < CMAX) m_cnt++;
      if (m_q.size() < DEPTH) m_q.push_back(8'((c << 6) | tv));
      else m_ovf = 1;
    end
  endtask

  task automatic check_all();
    chk("time_out",   32'(time_out),   32'(m_tout));
    chk("head_data",  32'(head_data),  (m_q.size() > 0) ? 32'(m_q[0]) : 32'h0);
    chk("fifo_empty", 32'(fifo_empty), 32'(m_q.size() == 0));
    chk("fifo_ovf",   32'(fifo_ovf),   32'(m_ovf));
    chk("seq_err",    32'(seq_err),    32'(m_seq));
    chk("locked",     32'(locked),     32'(m_locked));
    chk("tick_count", 32'(tick_count), 32'(m_cnt));
  endtask

  task automatic cyc(input bit t, input int tv, input int c, input bit p, input bit cl);
    @(negedge clk);
    tick_in = t; time_in = 6'(tv); ctrl_in = 2'(c); pop = p; clear = cl;
    @(posedge clk);
    model_step(t, tv, c, p, cl);
    #1;
    tick_in = 0; pop = 0; clear = 0;
    check_all();
  endtask

  task automatic do_reset(input bit noisy);
    @(negedge clk);
    reset = 1;
    tick_in = noisy; time_in = 6'($urandom_range(0, 63)); pop = noisy; clear = 0;
    @(posedge clk);
    model_reset();
    #1;
    reset = 0; tick_in = 0; pop = 0;
    check_all();
  endtask

  task automatic tick(input int tv); cyc(1, tv, 0, 0, 0); endtask

  initial begin
    int tv, c;
    bit t, p, cl;
    model_reset();
    do_reset(0);

    // 1: in-sequence codes
    tick(5); tick(6); tick(7);
    chk("t1_head", 32'(head_data), 32'h05);
    chk("t1_lock", 32'(locked), 32'd1);

    // 2: mod-64 wrap
    cyc(0, 0, 0, 0, 1);
    tick(62); tick(63); tick(0);
    chk("t2_seq", 32'(seq_err), 32'd0);
    chk("t2_cnt", 32'(tick_count), 32'd3);

    // 3: slip and relock
    cyc(0, 0, 0, 0, 1);
    tick(10); tick(12);
    chk("t3_slip", 32'(locked), 32'd0);
    tick(13);
    chk("t3_relock", 32'(locked), 32'd1);
    chk("t3_sticky", 32'(seq_err), 32'd1);

    // 4: overflow then drain, extra pop ignored
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) cyc(1, 20 + i, i % 4, 0, 0);
    chk("t4_ovf", 32'(fifo_ovf), 32'd1);
    chk("t4_head", 32'(head_data), 32'h14);
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0);
    chk("t4_empty", 32'(fifo_empty), 32'd1);

    // 5: full + simultaneous tick/pop
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) cyc(1, 30 + i, 1, 0, 0);
    cyc(1, 34, 3, 1, 0);
    chk("t5_ovf", 32'(fifo_ovf), 32'd0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1, 0);
    chk("t5_tail", 32'(head_data), 32'hE2);

    // 6: saturation, clear beats same-cycle tick
    cyc(0, 0, 0, 0, 1);
    for (int i = 0; i < 20; i++) cyc(1, i, 0, 1, 0);
    chk("t6_sat", 32'(tick_count), 32'hF);
    cyc(1, 40, 2, 0, 1);
    chk("t6_clr_cnt", 32'(tick_count), 32'd0);
    chk("t6_tout", 32'(time_out), 32'd19);
    tick(7);
    chk("t6_idle_lock", 32'(seq_err), 32'd0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset(1);
      end else begin
        t  = ($urandom_range(0, 1) == 1);
        tv = ($urandom_range(0, 2) != 0) ? ((m_last + 1) % 64) : int'($urandom_range(0, 63));
        c  = $urandom_range(0, 3);
        p  = ($urandom_range(0, 2) == 0);
        cl = ($urandom_range(0, 39) == 0);
        cyc(t, tv, c, p, cl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
